cpu_fsm_controller: RTL and testbench

Multi-cycle Moore controller for the Simple RISC Machine CPU. It sits between the instruction decoder and the datapath. It takes the decoded opcode/op fields and the start strobe `s`, then sequences register-file reads and writes, operand loads, ALU result capture and status capture for MOV, ADD, CMP, AND and MVN. It also drives the `w` "waiting" indication seen at the CPU top level.

---
 rtl/cpu_fsm_controller.sv | 178 +++++++++++++++++
 tb/tb_cpu_fsm_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fsm_controller.sv
// Moore sequencer for the Simple RISC Machine datapath (MOV, ADD, CMP, AND, MVN).
// Define FSM_ILLEGAL_TRAP_EN to latch illegal instructions into a sticky TRAP state.
module cpu_fsm_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       err
);

`ifdef FSM_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        ST_WAIT, ST_DECODE, ST_WRITE_IMM, ST_GET_A, ST_GET_B, ST_ALU, ST_WRITE_REG, ST_TRAP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_WAIT, ST_DECODE, ST_WRITE_IMM, ST_GET_A, ST_GET_B, ST_ALU, ST_WRITE_REG
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [2:0] opc_q, opc_d;
    logic [1:0] op_q, op_d;
    logic       w_q, w_d;
    logic [2:0] nsel_q, nsel_d;
    logic [1:0] vsel_q, vsel_d;
    logic       write_q, write_d;
    logic       loada_q, loada_d;
    logic       loadb_q, loadb_d;
    logic       loadc_q, loadc_d;
    logic       loads_q, loads_d;
    logic       asel_q, asel_d;
    logic       bsel_q, bsel_d;
    logic       err_q, err_d;
    logic       is_cmp_d, is_movr_d, is_mvn_d;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        op_d    = op_q;
        case (state_q)
            ST_WAIT: begin
                if (s) begin
                    state_d = ST_DECODE;
                    opc_d   = opcode;
                    op_d    = op;
                end
            end
            ST_DECODE: begin
                case ({opc_q, op_q})
                    5'b110_10:                      state_d = ST_WRITE_IMM;
                    5'b110_00, 5'b101_11:           state_d = ST_GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: state_d = ST_GET_A;
`ifdef FSM_ILLEGAL_TRAP_EN
                    default:                        state_d = ST_TRAP;
`else
                    default:                        state_d = ST_WAIT;
`endif
                endcase
            end
            ST_WRITE_IMM: state_d = ST_WAIT;
            ST_GET_A:     state_d = ST_GET_B;
            ST_GET_B:     state_d = ST_ALU;
            ST_ALU:       state_d = ({opc_q, op_q} == 5'b101_01) ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_d = ST_WAIT;
`ifdef FSM_ILLEGAL_TRAP_EN
            ST_TRAP:      state_d = ST_TRAP;
`endif
            default:      state_d = ST_WAIT;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without lag.
    assign is_cmp_d  = ({opc_d, op_d} == 5'b101_01);
    assign is_movr_d = ({opc_d, op_d} == 5'b110_00);
    assign is_mvn_d  = ({opc_d, op_d} == 5'b101_11);

    always_comb begin
        w_d     = 1'b0;
        nsel_d  = 3'b000;
        vsel_d  = 2'b00;
        write_d = 1'b0;
        loada_d = 1'b0;
        loadb_d = 1'b0;
        loadc_d = 1'b0;
        loads_d = 1'b0;
        asel_d  = 1'b0;
        bsel_d  = 1'b0;
        err_d   = 1'b0;
        case (state_d)
            ST_WAIT: w_d = 1'b1;
            ST_WRITE_IMM: begin
                nsel_d  = 3'b100;
                vsel_d  = 2'b10;
                write_d = 1'b1;
            end
            ST_GET_A: begin
                nsel_d  = 3'b100;
                loada_d = 1'b1;
            end
            ST_GET_B: begin
                nsel_d  = 3'b001;
                loadb_d = 1'b1;
            end
            ST_ALU: begin
                loadc_d = 1'b1;
                asel_d  = is_movr_d | is_mvn_d;
                loads_d = is_cmp_d;
            end
            ST_WRITE_REG: begin
                nsel_d  = 3'b010;
                write_d = 1'b1;
            end
`ifdef FSM_ILLEGAL_TRAP_EN
            ST_TRAP: err_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT;
            opc_q   <= 3'b000;
            op_q    <= 2'b00;
            w_q     <= 1'b1;
            nsel_q  <= 3'b000;
            vsel_q  <= 2'b00;
            write_q <= 1'b0;
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            loadc_q <= 1'b0;
            loads_q <= 1'b0;
            asel_q  <= 1'b0;
            bsel_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            op_q    <= op_d;
            w_q     <= w_d;
            nsel_q  <= nsel_d;
            vsel_q  <= vsel_d;
            write_q <= write_d;
            loada_q <= loada_d;
            loadb_q <= loadb_d;
            loadc_q <= loadc_d;
            loads_q <= loads_d;
            asel_q  <= asel_d;
            bsel_q  <= bsel_d;
            err_q   <= err_d;
        end
    end

    assign w     = w_q;
    assign nsel  = nsel_q;
    assign vsel  = vsel_q;
    assign write = write_q;
    assign loada = loada_q;
    assign loadb = loadb_q;
    assign loadc = loadc_q;
    assign loads = loads_q;
    assign asel  = asel_q;
    assign bsel  = bsel_q;
    assign err   = err_q;

endmodule

// File: tb/tb_cpu_fsm_controller.sv
// Bench for cpu_fsm_controller: instruction table, hand-written corner sequences,
// and random traffic compared against a per-instruction phase-list model.
module tb_cpu_fsm_controller;

    logic       clk;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w, write, loada, loadb, loadc, loads, asel, bsel, err;
    logic [2:0] nsel;
    logic [1:0] vsel;

    cpu_fsm_controller dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] dut_vec;
    assign dut_vec = {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, err};

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [13:0] exp_vec;
    logic [13:0] q[$];
    bit          trapped = 1'b0;

    // f = {w, write, loada, loadb, loadc, loads, asel, err}
    function automatic logic [13:0] ov(input logic [2:0] ns, input logic [1:0] vs, input logic [7:0] f);
        return {f[7], ns, vs, f[6], f[5], f[4], f[3], f[2], f[1], 1'b0, f[0]};
    endfunction

    function automatic logic [13:0] v_wait();
        return ov(3'b000, 2'b00, 8'b1000_0000);
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b (w nsel vsel wr la lb lc ls as bs err)", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Each instruction is a list of per-cycle output words ending in the WAIT word.
    task automatic build(input logic [2:0] oc, input logic [1:0] o);
        logic [13:0] dec, ga, gb, alu_p, alu_a, alu_c, wr, wt;
        dec   = ov(3'b000, 2'b00, 8'b0000_0000);
        ga    = ov(3'b100, 2'b00, 8'b0010_0000);
        gb    = ov(3'b001, 2'b00, 8'b0001_0000);
        alu_p = ov(3'b000, 2'b00, 8'b0000_1000);
        alu_a = ov(3'b000, 2'b00, 8'b0000_1010);
        alu_c = ov(3'b000, 2'b00, 8'b0000_1100);
        wr    = ov(3'b010, 2'b00, 8'b0100_0000);
        wt    = v_wait();
        q.push_back(dec);
        case ({oc, o})
            5'b110_10: begin q.push_back(ov(3'b100, 2'b10, 8'b0100_0000)); q.push_back(wt); end
            5'b110_00, 5'b101_11: begin
                q.push_back(gb); q.push_back(alu_a); q.push_back(wr); q.push_back(wt);
            end
            5'b101_00, 5'b101_10: begin
                q.push_back(ga); q.push_back(gb); q.push_back(alu_p); q.push_back(wr); q.push_back(wt);
            end
            5'b101_01: begin
                q.push_back(ga); q.push_back(gb); q.push_back(alu_c); q.push_back(wt);
            end
            default: begin
`ifdef FSM_ILLEGAL_TRAP_EN
                q.push_back(ov(3'b000, 2'b00, 8'b0000_0001));
                trapped = 1'b1;
`else
                q.push_back(wt);
`endif
            end
        endcase
    endtask

    task automatic model_edge();
        if (!reset) begin
            q.delete();
            trapped = 1'b0;
            exp_vec = v_wait();
        end else if (q.size() > 0) begin
            exp_vec = q.pop_front();
        end else if (trapped) begin
            exp_vec = ov(3'b000, 2'b00, 8'b0000_0001);
        end else if (s) begin
            build(opcode, op);
            exp_vec = q.pop_front();
        end else begin
            exp_vec = v_wait();
        end
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        model_edge();
        #2;
        check(name, dut_vec, exp_vec);
    endtask

    task automatic async_reset(input string name);
        reset = 1'b0;
        #1;
        q.delete();
        trapped = 1'b0;
        exp_vec = v_wait();
        check(name, dut_vec, exp_vec);
        tick({name, "_hold"});
        reset = 1'b1;
    endtask

    task automatic run_instr(input string name, input logic [2:0] oc, input logic [1:0] o,
                             input logic [2:0] post_oc, input logic [1:0] post_o,
                             input int exp_cyc, input int exp_wr, input int exp_ld);
        int edges, writes, lds;
        opcode = oc; op = o; s = 1'b1;
        tick(name);
        s = 1'b0; opcode = post_oc; op = post_o;
        edges = 1; writes = int'(write); lds = int'(loads);
        while (w !== 1'b1 && edges < 20) begin
            tick(name);
            edges++;
            writes += int'(write);
            lds    += int'(loads);
        end
        check_int({name, "_cycles"}, edges, exp_cyc);
        check_int({name, "_writes"}, writes, exp_wr);
        check_int({name, "_loads"}, lds, exp_ld);
    endtask

    typedef struct {
        logic [2:0] oc;
        logic [1:0] o;
        int         cyc;
        int         wr;
        int         ld;
    } vec_t;

    vec_t tbl [8];
    int   n_tbl;

    initial begin
        int w_cnt;
        tbl[0] = '{3'b110, 2'b10, 3, 1, 0};
        tbl[1] = '{3'b110, 2'b00, 5, 1, 0};
        tbl[2] = '{3'b101, 2'b00, 6, 1, 0};
        tbl[3] = '{3'b101, 2'b01, 5, 0, 1};
        tbl[4] = '{3'b101, 2'b10, 6, 1, 0};
        tbl[5] = '{3'b101, 2'b11, 5, 1, 0};
        tbl[6] = '{3'b111, 2'b00, 2, 0, 0};
        tbl[7] = '{3'b000, 2'b01, 2, 0, 0};
`ifdef FSM_ILLEGAL_TRAP_EN
        n_tbl = 6;
`else
        n_tbl = 8;
`endif

        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        exp_vec = v_wait();
        #1 reset = 1'b0;
        #1 check("reset_state", dut_vec, v_wait());
        s = 1'b1;
        tick("reset_ignores_s");
        s = 1'b0;
        tick("reset_hold");
        reset = 1'b1;

        for (int i = 0; i < n_tbl; i++)
            run_instr($sformatf("tbl%0d", i), tbl[i].oc, tbl[i].o,
                      3'($urandom), 2'($urandom), tbl[i].cyc, tbl[i].wr, tbl[i].ld);

        run_instr("latch_fields", 3'b110, 2'b10, 3'b101, 2'b00, 3, 1, 0);

        opcode = 3'b101; op = 2'b00; s = 1'b1;
        tick("add_rst_sample");
        s = 1'b0;
        for (int i = 0; i < 3; i++) tick("add_rst_run");
        check_int("add_in_alu_loadc", int'(loadc), 1);
        reset = 1'b0;
        #1;
        check_int("add_rst_no_write", int'(write), 0);
        q.delete();
        exp_vec = v_wait();
        check("add_rst_outputs", dut_vec, exp_vec);
        tick("add_rst_hold");
        check_int("add_rst_hold_no_write", int'(write), 0);
        reset = 1'b1;
        tick("add_rst_release");

        opcode = 3'b110; op = 2'b10; s = 1'b1;
        w_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick("s_held");
            w_cnt += int'(w);
        end
        check_int("s_held_w_cycles", w_cnt, 1);
        s = 1'b0;
        tick("s_held_end");
        tick("s_held_idle");

`ifdef FSM_ILLEGAL_TRAP_EN
        opcode = 3'b111; op = 2'b00; s = 1'b1;
        tick("trap_sample");
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom); opcode = 3'($urandom); op = 2'($urandom);
            tick("trap_hold");
        end
        check_int("trap_err", int'(err), 1);
        check_int("trap_w", int'(w), 0);
        async_reset("trap_clear");
`endif

        for (int i = 0; i < 400; i++) begin
            int k;
            s = ($urandom_range(0, 2) != 0);
`ifdef FSM_ILLEGAL_TRAP_EN
            k = $urandom_range(0, 5);
`else
            k = $urandom_range(0, 7);
`endif
            opcode = tbl[k].oc;
            op     = tbl[k].o;
            if (k == 7) begin
                opcode = 3'($urandom);
                op     = 2'($urandom);
            end
            if ($urandom_range(0, 60) == 0) async_reset("rand_reset");
            else tick("random");
        end

        s = 1'b0;
        for (int i = 0; i < 8; i++) tick("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
